// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_pkg;

    localparam int REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: the ID instruction reads a register that the
// load currently in ID/EX has not yet produced.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] idRs,
    input  logic [REG_ADDR_W-1:0] idRt,
    input  logic                  idUsesRs,
    input  logic                  idUsesRt,
    input  logic                  exMemRead,
    input  logic [REG_ADDR_W-1:0] exWriteReg,
    output logic                  loadUse
);

    // Either used source operand matching the load destination is a hazard
    always_comb begin
        loadUse = exMemRead &
                  ((idUsesRs & (idRs == exWriteReg)) |
                   (idUsesRt & (idRt == exWriteReg)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: register enables/flushes for the
// five-stage core, data-memory wait FSM, halt freeze and stall counter.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] idRs,
    input  logic [REG_ADDR_W-1:0] idRt,
    input  logic                  idUsesRs,
    input  logic                  idUsesRt,
    input  logic                  exMemRead,
    input  logic [REG_ADDR_W-1:0] exWriteReg,
    input  logic                  branchTaken,
    input  logic                  imemBusy,
    input  logic                  memAccess,
    input  logic                  dmemDone,
    input  logic                  wbHalt,
    output logic                  pcEn,
    output logic                  ifidEn,
    output logic                  idexEn,
    output logic                  exmemEn,
    output logic                  memwbEn,
    output logic                  ifidFlush,
    output logic                  idexFlush,
    output logic                  dmemStart,
    output logic                  halted,
    output logic [CNT_W-1:0]      stallCycles
);

    pipe_state_t state;
    pipe_state_t stateNext;
    logic        loadUse;
    logic        applyRules;

    hazard_detect uHazard (
        .idRs       (idRs),
        .idRt       (idRt),
        .idUsesRs   (idUsesRs),
        .idUsesRt   (idUsesRt),
        .exMemRead  (exMemRead),
        .exWriteReg (exWriteReg),
        .loadUse    (loadUse)
    );

    // State, halt flag and saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            halted      <= 1'b0;
            stallCycles <= '0;
        end else begin
            state  <= stateNext;
            halted <= (stateNext == HALT);
            if (!pcEn && (state != HALT) && (stallCycles != '1)) begin
                stallCycles <= stallCycles + CNT_W'(1);
            end
        end
    end

    // Next state and combinational enables/flushes
    always_comb begin
        pcEn       = 1'b1;
        ifidEn     = 1'b1;
        idexEn     = 1'b1;
        exmemEn    = 1'b1;
        memwbEn    = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        dmemStart  = 1'b0;
        stateNext  = state;
        applyRules = 1'b0;

        if (!rst) begin
            // Enables held high so the pipeline registers load their own reset
            stateNext = RUN;
        end else begin
            case (state)
                RUN: begin
                    dmemStart = memAccess;
                    if (memAccess && !dmemDone) begin
                        pcEn      = 1'b0;
                        ifidEn    = 1'b0;
                        idexEn    = 1'b0;
                        exmemEn   = 1'b0;
                        memwbEn   = 1'b0;
                        stateNext = DWAIT;
                    end else begin
                        applyRules = 1'b1;
                    end
                    if (wbHalt) begin
                        stateNext = HALT;
                    end
                end
                DWAIT: begin
                    if (!dmemDone) begin
                        pcEn    = 1'b0;
                        ifidEn  = 1'b0;
                        idexEn  = 1'b0;
                        exmemEn = 1'b0;
                        memwbEn = 1'b0;
                    end else begin
                        stateNext  = RUN;
                        applyRules = 1'b1;
                    end
                end
                HALT: begin
                    pcEn    = 1'b0;
                    ifidEn  = 1'b0;
                    idexEn  = 1'b0;
                    exmemEn = 1'b0;
                    memwbEn = 1'b0;
                end
                default: begin
                    stateNext = RUN;
                end
            endcase
        end

        // Shared hazard priority for RUN and the DWAIT completion cycle;
        // a load-use stall holds a taken branch in ID for re-resolution
        if (applyRules) begin
            if (loadUse) begin
                pcEn      = 1'b0;
                ifidEn    = 1'b0;
                idexFlush = 1'b1;
            end else if (branchTaken) begin
                ifidFlush = 1'b1;
            end else if (imemBusy) begin
                pcEn      = 1'b0;
                ifidFlush = 1'b1;
            end
        end
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 16-bit, five-stage core. Drives the write enables and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Stalls and squashes stages for load-use hazards, taken branches, instruction-fetch waits and multicycle data-memory accesses, and freezes the machine after HLT retires. Sits beside the datapath; all outputs go straight to the register `en`/flush inputs.

## Interface
- `CNT_W`, 16, width of the saturating stall-cycle counter.

- `clk`  in  1  core clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `idRs`, `idRt`  in  4 each  source registers of the instruction in ID.
- `idUsesRs`, `idUsesRt`  in  1 each  ID instruction reads `idRs`/`idRt`.
- `exMemRead`  in  1  ID/EX holds a load.
- `exWriteReg`  in  4  destination register of the ID/EX instruction.
- `branchTaken`  in  1  branch or jump resolved taken in ID.
- `imemBusy`  in  1  instruction memory has no valid word this cycle.
- `memAccess`  in  1  EX/MEM holds a load or store.
- `dmemDone`  in  1  data memory completes the access this cycle.
- `wbHalt`  in  1  `haltOut` of the MEM/WB register.
- `pcEn`, `ifidEn`, `idexEn`, `exmemEn`, `memwbEn`  out  1 each  register write enables.
- `ifidFlush`, `idexFlush`  out  1 each  load a NOP/bubble instead of the incoming values. Takes effect only when the matching enable is 1.
- `dmemStart`  out  1  one-cycle start pulse for a data-memory access.
- `halted`  out  1  processor frozen.
- `stallCycles`  out  `CNT_W`  count of cycles with `pcEn`=0.

## Operation
- States: RUN, DWAIT, HALT.
- Load-use condition: `loadUse = exMemRead & ((idUsesRs & idRs==exWriteReg) | (idUsesRt & idRt==exWriteReg))`.
- RUN output priority, first match wins:
  1. `memAccess & !dmemDone`: all five enables 0. Next state DWAIT.
  2. `loadUse`: `pcEn`=`ifidEn`=0, `idexFlush`=1. Other enables 1.
  3. `branchTaken`: `ifidFlush`=1. All enables 1.
  4. `imemBusy`: `pcEn`=0, `ifidFlush`=1. Other enables 1.
  5. Otherwise: all enables 1, flushes 0.
- `dmemStart` = 1 in RUN whenever `memAccess`=1, including the case `dmemDone`=1 in the same cycle (single-cycle hit, no stall).
- DWAIT:
  - `dmemStart`=0.
  - While `dmemDone`=0: all enables 0.
  - On `dmemDone`=1: return to RUN. In that same cycle, outputs are those of RUN rules 2–5, evaluated with the current inputs.
- Load-use and taken branch together: the stall wins. The branch stays in ID and is re-resolved next cycle.
- RUN with `wbHalt`=1:
  - Next state HALT. This takes precedence over entering DWAIT.
  - Outputs this cycle still follow the RUN rules.
- HALT:
  - All enables 0, flushes 0, `dmemStart`=0.
  - `halted`=1 (registered).
  - Left only by reset.
- `stallCycles`:
  - Increments on every edge where `pcEn`=0 and the state is not HALT.
  - Saturates at all-ones, never wraps.
  - Width arithmetic is unsigned, `CNT_W` bits.

## Timing
- Enables and flushes are combinational from inputs and state, valid in the same cycle. No added latency.
- State, `halted` and `stallCycles` are registered.
- Reset (`rst`=0 at an edge, from any state, including mid-DWAIT):
  - Next state RUN, `halted`=0, `stallCycles`=0.
  - While `rst`=0: all enables 1, flushes 0, `dmemStart`=0. This lets the pipeline registers' own resets load.
- A memory access that is pending when reset is applied is abandoned. Data memory must tolerate a missing completion.
- Load-use stalls last exactly 1 cycle.
- A DWAIT of N wait cycles stalls for N cycles, plus 0 if done is asserted on the first cycle.

## Structure
- Shared package `pipe_pkg`:
  - state enum `pipe_state_t` {RUN, DWAIT, HALT}
  - constant `REG_ADDR_W`=4
- Sub-module `hazard_detect`: combinational `loadUse` comparator. Reusable by a later forwarding unit.
- Top-level contents: FSM, output priority logic, saturating counter.

## Test plan
- Load-use: `exMemRead`=1, `exWriteReg`=3, `idRs`=3, `idUsesRs`=1 for 1 cycle -> `pcEn`=`ifidEn`=0, `idexFlush`=1, `stallCycles` 0→1.
- Branch plus load-use in the same cycle -> stall outputs only, `ifidFlush`=0. Next cycle, `branchTaken` alone -> `ifidFlush`=1.
- `memAccess`=1 with `dmemDone` raised after 3 cycles -> `dmemStart` high exactly 1 cycle, all enables 0 for 3 cycles, all enables 1 on the done cycle, `stallCycles`=3.
- Single-cycle hit (`memAccess`=`dmemDone`=1) -> `dmemStart`=1, no stall, state stays RUN.
- `wbHalt`=1 -> `halted`=1 next cycle, enables 0 thereafter. `rst`=0 for 1 cycle -> `halted`=0, `stallCycles`=0, RUN.
- `CNT_W`=4, `imemBusy` held 20 cycles -> `stallCycles` saturates at 15. `rst` asserted mid-DWAIT -> RUN, enables 1.
